// File: rtl/vga_text_pkg.sv
// Shared definitions for the text-display VRAM writer: geometry defaults,
// control codes, blank character and the writer FSM state type.
package vga_text_pkg;

    localparam int COLS_DEF = 40;
    localparam int ROWS_DEF = 30;

    localparam logic [7:0] CC_BS    = 8'h08;
    localparam logic [7:0] CC_LF    = 8'h0A;
    localparam logic [7:0] CC_FF    = 8'h0C;
    localparam logic [7:0] CC_CR    = 8'h0D;
    localparam logic [7:0] CC_DEL   = 8'h7F;
    localparam logic [7:0] CH_BLANK = 8'h20;

    typedef enum logic [1:0] {
        CLR_ALL  = 2'd0,
        IDLE     = 2'd1,
        CLR_LINE = 2'd2
    } state_t;

    // Everything from space upward except DEL lands in a cell.
    function automatic logic is_printable(input logic [7:0] c);
        return (c >= CH_BLANK) && (c != CC_DEL);
    endfunction

endpackage

// File: rtl/vga_text_writer.sv
// Byte-stream to text-VRAM writer. Accepts characters and control codes over
// valid/ready and turns them into {attr, char} cell writes at a tracked cursor.
// No scrolling: the cursor wraps from the last row to row 0 and the row it
// lands on is cleared.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  CLR_ALL  | blanking every cell 0..COLS*ROWS-1, then cursor to (0,0)
//  IDLE     | accepting bytes; printables write one cell per cycle
//  CLR_LINE | blanking the COLS cells of the current cursor row
module vga_text_writer
    import vga_text_pkg::*;
#(
    parameter int         COLS     = COLS_DEF,
    parameter int         ROWS     = ROWS_DEF,
    parameter int         AW       = 11,
    parameter logic [7:0] CLR_ATTR = 8'h00
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    input  logic [7:0]    in_attr,
    output logic          in_ready,
    output logic          vram_we,
    output logic [AW-1:0] vram_waddr,
    output logic [15:0]   vram_wdata,
    output logic [5:0]    cursor_col,
    output logic [4:0]    cursor_row,
    output logic          busy
);

    localparam int CW = $clog2(COLS * ROWS);

    state_t          state_q, state_d;
    logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [5:0]      col_q, col_d;
    logic [4:0]      row_q, row_d;
    logic [AW-1:0]   base_q, base_d;
    logic            we_q, we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;

    logic            accept;
    logic            last_row;
    logic [4:0]      row_nxt;
    logic [AW-1:0]   base_nxt;

    assign accept   = in_valid && in_ready_q;
    assign last_row = (row_q == 5'(ROWS - 1));
    // Line base tracks row*COLS incrementally so no multiplier is needed.
    assign row_nxt  = last_row ? 5'd0 : row_q + 5'd1;
    assign base_nxt = last_row ? '0 : base_q + AW'(COLS);

    // Next-state and registered-output decode.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        col_d      = col_q;
        row_d      = row_q;
        base_d     = base_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        in_ready_d = 1'b0;
        busy_d     = 1'b0;

        case (state_q)
            CLR_ALL: begin
                we_d    = 1'b1;
                busy_d  = 1'b1;
                waddr_d = AW'(clr_cnt_q);
                wdata_d = {CLR_ATTR, CH_BLANK};
                if (clr_cnt_q == CW'(COLS * ROWS - 1)) begin
                    clr_cnt_d = '0;
                    state_d   = IDLE;
                    col_d     = '0;
                    row_d     = '0;
                    base_d    = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + CW'(1);
                end
            end

            CLR_LINE: begin
                we_d    = 1'b1;
                busy_d  = 1'b1;
                waddr_d = base_q + AW'(clr_cnt_q);
                wdata_d = {CLR_ATTR, CH_BLANK};
                if (clr_cnt_q == CW'(COLS - 1)) begin
                    clr_cnt_d = '0;
                    state_d   = IDLE;
                    col_d     = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + CW'(1);
                end
            end

            IDLE: begin
                if (accept) begin
                    if (is_printable(in_data)) begin
                        we_d    = 1'b1;
                        waddr_d = base_q + AW'(col_q);
                        wdata_d = {in_attr, in_data};
                        if (col_q == 6'(COLS - 1)) begin
                            col_d   = '0;
                            row_d   = row_nxt;
                            base_d  = base_nxt;
                            state_d = CLR_LINE;
                        end else begin
                            col_d = col_q + 6'd1;
                        end
                    end else begin
                        case (in_data)
                            CC_LF: begin
                                col_d   = '0;
                                row_d   = row_nxt;
                                base_d  = base_nxt;
                                state_d = CLR_LINE;
                            end
                            CC_CR: col_d = '0;
                            CC_BS: begin
                                if (col_q != '0) col_d = col_q - 6'd1;
                            end
                            CC_FF: state_d = CLR_ALL;
                            default: ;
                        endcase
                    end
                end
                // Ready only stays up while we remain idle; a pending clear
                // drops it in the same cycle the triggering byte's effect shows.
                in_ready_d = (state_d == IDLE);
                busy_d     = (state_d != IDLE);
            end

            default: state_d = CLR_ALL;
        endcase
    end

    // State, counters and output registers; reset forces a fresh full clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLR_ALL;
            clr_cnt_q  <= '0;
            col_q      <= '0;
            row_q      <= '0;
            base_q     <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            col_q      <= col_d;
            row_q      <= row_d;
            base_q     <= base_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign vram_we    = we_q;
    assign vram_waddr = waddr_q;
    assign vram_wdata = wdata_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_vga_text_writer.sv
// Directed bench for vga_text_writer: full clear, printables, wrap with line
// clear, control codes and reset abort during a clear.
module tb_vga_text_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [7:0]  in_attr;
    logic        in_ready;
    logic        vram_we;
    logic [10:0] vram_waddr;
    logic [15:0] vram_wdata;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vga_text_writer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_attr    (in_attr),
        .in_ready   (in_ready),
        .vram_we    (vram_we),
        .vram_waddr (vram_waddr),
        .vram_wdata (vram_wdata),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_cursor(input string tag, input int c, input int r);
        chk(tag, {21'd0, cursor_col, cursor_row}, {21'd0, 6'(c), 5'(r)});
    endtask

    task automatic chk_write(input string tag, input int addr, input logic [15:0] data);
        chk(tag, {4'd0, vram_we, vram_waddr, vram_wdata}, {4'd0, 1'b1, 11'(addr), data});
    endtask

    task automatic chk_nowrite(input string tag);
        chk(tag, {31'd0, vram_we}, 32'd0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ctl"}, {29'd0, vram_we, in_ready, busy}, 32'd0);
        chk({tag, "_addr"}, {21'd0, vram_waddr}, 32'd0);
        chk({tag, "_data"}, {16'd0, vram_wdata}, 32'd0);
        chk({tag, "_cur"}, {21'd0, cursor_col, cursor_row}, 32'd0);
    endtask

    // Checks n consecutive blank writes starting at the current negedge.
    task automatic expect_clear(input string tag, input int start, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, {2'd0, vram_we, busy, in_ready, vram_waddr, vram_wdata},
                     {2'd0, 1'b1, 1'b1, 1'b0, 11'(start + i), 16'h0020});
            @(negedge clk);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!in_ready && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    // Returns at the negedge of the cycle after acceptance.
    task automatic send_byte(input logic [7:0] d, input logic [7:0] a);
        wait_ready();
        in_valid = 1'b1;
        in_data  = d;
        in_attr  = a;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_attr  = 8'h00;

        // Reset state and power-up clear
        repeat (3) @(negedge clk);
        chk_reset_outs("rst");
        reset = 1'b0;
        @(negedge clk);
        expect_clear("clr_all", 0, 1200);
        chk("clr_done_busy", {31'd0, busy}, 32'd0);
        wait_ready();
        chk_cursor("cur_after_clr", 0, 0);

        // Single printable, then a back-to-back burst
        in_valid = 1'b1;
        in_data  = 8'h41;
        in_attr  = 8'h07;
        @(negedge clk);
        chk_write("wr_A", 0, 16'h0741);
        chk_cursor("cur_A", 1, 0);
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(8'h41 + i);
            @(negedge clk);
            chk_write("b2b", 1 + i, {8'h07, 8'(8'h41 + i)});
        end
        in_valid = 1'b0;
        chk_cursor("cur_b2b", 4, 0);

        // Full row of printables -> wrap and clear of row 1
        send_byte(8'h0D, 8'h00);
        chk_nowrite("cr_nowrite");
        chk_cursor("cur_cr", 0, 0);
        in_valid = 1'b1;
        in_attr  = 8'h1E;
        for (int i = 0; i < 40; i++) begin
            in_data = 8'(8'h21 + i);
            @(negedge clk);
            chk_write("row0", i, {8'h1E, 8'(8'h21 + i)});
        end
        in_valid = 1'b0;
        chk_cursor("cur_wrap", 0, 1);
        chk("wrap_busy_rdy", {30'd0, busy, in_ready}, 32'd2);
        @(negedge clk);
        expect_clear("clr_line1", 40, 40);
        chk("line_done_busy", {31'd0, busy}, 32'd0);

        // Walk to row 29 col 5, then LF wraps to row 0 and clears it
        for (int k = 0; k < 28; k++) send_byte(8'h0A, 8'h00);
        chk_cursor("cur_row29", 0, 29);
        for (int k = 0; k < 5; k++) send_byte(8'(8'h61 + k), 8'h02);
        chk_write("row29_wr", 1164, 16'h0265);
        chk_cursor("cur_29_5", 5, 29);
        send_byte(8'h0A, 8'h00);
        chk_nowrite("lf_nowrite");
        chk_cursor("cur_lf_wrap", 0, 0);
        @(negedge clk);
        expect_clear("clr_wrap", 0, 40);

        // BS at col 0, CR, BS, ignored codes, high printable
        send_byte(8'h08, 8'h00);
        chk_nowrite("bs0_nowrite");
        chk_cursor("cur_bs0", 0, 0);
        for (int k = 0; k < 3; k++) send_byte(8'h0A, 8'h00);
        for (int k = 0; k < 10; k++) send_byte(8'(8'h30 + k), 8'h05);
        chk_write("row3_wr", 129, 16'h0539);
        chk_cursor("cur_10_3", 10, 3);
        send_byte(8'h0D, 8'h00);
        chk_nowrite("cr3_nowrite");
        chk_cursor("cur_cr3", 0, 3);
        send_byte(8'h42, 8'h1F);
        chk_write("wr_B", 120, 16'h1F42);
        chk_cursor("cur_B", 1, 3);
        send_byte(8'h08, 8'h00);
        chk_nowrite("bs_nowrite");
        chk_cursor("cur_bs", 0, 3);
        send_byte(8'h07, 8'h00);
        chk_nowrite("bel_nowrite");
        chk_cursor("cur_bel", 0, 3);
        send_byte(8'h7F, 8'h00);
        chk_nowrite("del_nowrite");
        chk_cursor("cur_del", 0, 3);
        send_byte(8'hA5, 8'h3C);
        chk_write("wr_A5", 120, 16'h3CA5);
        chk_cursor("cur_A5", 1, 3);

        // FF clear, reset mid-clear, restart from 0
        send_byte(8'h0C, 8'h00);
        chk_nowrite("ff_nowrite");
        chk("ff_busy_rdy", {30'd0, busy, in_ready}, 32'd2);
        @(negedge clk);
        expect_clear("ff_clr", 0, 600);
        chk_write("ff_600", 600, 16'h0020);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outs("midrst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        expect_clear("restart", 0, 1200);
        wait_ready();
        chk_cursor("cur_final", 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
